// File: rtl/cdb_writeback_arbiter.sv
// rtl/cdb_writeback_arbiter.sv - per-unit result FIFOs round-robin serialised onto one registered CDB with mispredict squash

module cdb_wb_fifo #(
    parameter int DEPTH = 2,
    parameter int TAG_W = 5,
    parameter int ENT_W = 45
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             live,
    input  logic [TAG_W-1:0] rob_head,
    input  logic             flush,
    input  logic [TAG_W-1:0] flush_tag,
    input  logic             push_valid,
    input  logic [ENT_W-1:0] push_data,
    input  logic             pop,
    output logic             ready,
    output logic             head_valid,
    output logic [ENT_W-1:0] head_data
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [ENT_W-1:0] mem_d [DEPTH];
    logic [ENT_W-1:0] comp [DEPTH];
    logic [CW-1:0]    rank [DEPTH];
    logic [DEPTH-1:0] keep;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic [CW-1:0]    surv_cnt;
    logic [CW-1:0]    base_cnt;
    logic             push_ok;

    // Younger than the branch means strictly further from the ROB head, modulo the tag space.
    function automatic logic is_younger(input logic [TAG_W-1:0] t,
                                        input logic [TAG_W-1:0] head,
                                        input logic [TAG_W-1:0] br_tag);
        logic [TAG_W-1:0] age_t;
        logic [TAG_W-1:0] age_b;
        age_t = t - head;
        age_b = br_tag - head;
        return age_t > age_b;
    endfunction

    assign ready = live && (count_q < CW'(DEPTH));

    always_comb begin
        surv_cnt = '0;
        keep     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            keep[i] = (CW'(i) < count_q) &&
                      !(flush && is_younger(mem_q[i][ENT_W-1 -: TAG_W], rob_head, flush_tag));
            rank[i]  = surv_cnt;
            surv_cnt = surv_cnt + CW'(keep[i]);
        end
        // Survivors are packed towards slot 0 so age order is preserved after a squash.
        for (int j = 0; j < DEPTH; j++) begin
            comp[j] = '0;
            for (int i = 0; i < DEPTH; i++) begin
                if (keep[i] && (rank[i] == CW'(j))) begin
                    comp[j] = mem_q[i];
                end
            end
        end
    end

    assign head_valid = (surv_cnt != '0);
    assign head_data  = comp[0];

    always_comb begin
        push_ok  = push_valid && ready &&
                   !(flush && is_younger(push_data[ENT_W-1 -: TAG_W], rob_head, flush_tag));
        base_cnt = surv_cnt - CW'(pop);
        for (int j = 0; j < DEPTH - 1; j++) begin
            mem_d[j] = pop ? comp[j+1] : comp[j];
        end
        mem_d[DEPTH-1] = pop ? '0 : comp[DEPTH-1];
        for (int j = 0; j < DEPTH; j++) begin
            if (push_ok && (base_cnt == CW'(j))) begin
                mem_d[j] = push_data;
            end
        end
        count_d = base_cnt + CW'(push_ok);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule

module cdb_writeback_arbiter #(
    parameter int DEPTH  = 2,
    parameter int TAG_W  = 5,
    parameter int PREG_W = 7,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [TAG_W-1:0]  rob_head,
    input  logic              mispredict,
    input  logic [TAG_W-1:0]  mispredict_tag,
    input  logic              alu_valid,
    input  logic [TAG_W-1:0]  alu_rob_tag,
    input  logic [PREG_W-1:0] alu_pd,
    input  logic              alu_we,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              br_valid,
    input  logic [TAG_W-1:0]  br_rob_tag,
    input  logic [PREG_W-1:0] br_pd,
    input  logic              br_we,
    input  logic [DATA_W-1:0] br_data,
    input  logic              mem_valid,
    input  logic [TAG_W-1:0]  mem_rob_tag,
    input  logic [PREG_W-1:0] mem_pd,
    input  logic              mem_we,
    input  logic [DATA_W-1:0] mem_data,
    output logic              alu_ready,
    output logic              br_ready,
    output logic              mem_ready,
    output logic              cdb_valid,
    output logic [TAG_W-1:0]  cdb_rob_tag,
    output logic [PREG_W-1:0] cdb_pd,
    output logic              cdb_we,
    output logic [DATA_W-1:0] cdb_data
);

    localparam int ENT_W = TAG_W + PREG_W + 1 + DATA_W;

    logic              live_q;
    logic [1:0]        rr_q;
    logic [1:0]        win;
    logic              any_head;
    logic [2:0]        head_valid;
    logic [2:0]        pop;
    logic [2:0]        src_ready;
    logic [2:0]        src_valid;
    logic [ENT_W-1:0]  src_data [3];
    logic [ENT_W-1:0]  head_data [3];
    logic [ENT_W-1:0]  win_data;
    logic              cdb_valid_q;
    logic              cdb_we_q;
    logic [TAG_W-1:0]  cdb_tag_q;
    logic [PREG_W-1:0] cdb_pd_q;
    logic [DATA_W-1:0] cdb_data_q;

    assign src_valid   = {mem_valid, br_valid, alu_valid};
    assign src_data[0] = {alu_rob_tag, alu_pd, alu_we, alu_data};
    assign src_data[1] = {br_rob_tag, br_pd, br_we, br_data};
    assign src_data[2] = {mem_rob_tag, mem_pd, mem_we, mem_data};

    for (genvar g = 0; g < 3; g++) begin : g_src
        cdb_wb_fifo #(
            .DEPTH (DEPTH),
            .TAG_W (TAG_W),
            .ENT_W (ENT_W)
        ) u_fifo (
            .clk        (clk),
            .reset      (reset),
            .live       (live_q),
            .rob_head   (rob_head),
            .flush      (mispredict),
            .flush_tag  (mispredict_tag),
            .push_valid (src_valid[g]),
            .push_data  (src_data[g]),
            .pop        (pop[g]),
            .ready      (src_ready[g]),
            .head_valid (head_valid[g]),
            .head_data  (head_data[g])
        );
    end

    assign alu_ready = src_ready[0];
    assign br_ready  = src_ready[1];
    assign mem_ready = src_ready[2];

    // Readies stay low until the first edge after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            live_q <= 1'b0;
        end else begin
            live_q <= 1'b1;
        end
    end

    // Round-robin search over surviving heads, starting at rr_q in ALU, BR, MEM order.
    always_comb begin
        any_head = |head_valid;
        case (rr_q)
            2'd1:    win = head_valid[1] ? 2'd1 : (head_valid[2] ? 2'd2 : 2'd0);
            2'd2:    win = head_valid[2] ? 2'd2 : (head_valid[0] ? 2'd0 : 2'd1);
            default: win = head_valid[0] ? 2'd0 : (head_valid[1] ? 2'd1 : 2'd2);
        endcase
        pop = '0;
        if (any_head) begin
            pop[win] = 1'b1;
        end
        case (win)
            2'd1:    win_data = head_data[1];
            2'd2:    win_data = head_data[2];
            default: win_data = head_data[0];
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_q        <= 2'd0;
            cdb_valid_q <= 1'b0;
            cdb_we_q    <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_pd_q    <= '0;
            cdb_data_q  <= '0;
        end else if (any_head) begin
            rr_q        <= (win == 2'd2) ? 2'd0 : win + 2'd1;
            cdb_valid_q <= 1'b1;
            cdb_tag_q   <= win_data[ENT_W-1 -: TAG_W];
            cdb_pd_q    <= win_data[DATA_W+1 +: PREG_W];
            cdb_we_q    <= win_data[DATA_W];
            cdb_data_q  <= win_data[DATA_W-1:0];
        end else begin
            cdb_valid_q <= 1'b0;
        end
    end

    assign cdb_valid   = cdb_valid_q;
    assign cdb_rob_tag = cdb_tag_q;
    assign cdb_pd      = cdb_pd_q;
    assign cdb_we      = cdb_valid_q & cdb_we_q;
    assign cdb_data    = cdb_data_q;

endmodule

// File: tb/tb_cdb_writeback_arbiter.sv
// tb/tb_cdb_writeback_arbiter.sv - self-checking bench for cdb_writeback_arbiter with a queue-based reference model

module tb_cdb_writeback_arbiter;

    localparam int DEPTH = 2;

    typedef struct packed {
        logic [4:0]  tag;
        logic [6:0]  pd;
        logic        we;
        logic [31:0] data;
    } res_t;

    typedef struct {
        bit         av;
        logic [4:0] at;
        bit         bv;
        logic [4:0] bt;
        bit         mv;
        logic [4:0] mt;
        bit         ev;
        logic [4:0] et;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [4:0]  rob_head = '0;
    logic        mispredict = 1'b0;
    logic [4:0]  mispredict_tag = '0;
    logic        in_v [3];
    res_t        in_r [3];
    logic        alu_ready, br_ready, mem_ready;
    logic        cdb_valid, cdb_we;
    logic [4:0]  cdb_rob_tag;
    logic [6:0]  cdb_pd;
    logic [31:0] cdb_data;

    res_t mq [3][$];
    int   m_rr;
    bit   m_live;
    bit   m_valid;
    res_t m_cdb;
    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t tbl [10];

    always #5 clk = ~clk;

    cdb_writeback_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .rob_head       (rob_head),
        .mispredict     (mispredict),
        .mispredict_tag (mispredict_tag),
        .alu_valid      (in_v[0]),
        .alu_rob_tag    (in_r[0].tag),
        .alu_pd         (in_r[0].pd),
        .alu_we         (in_r[0].we),
        .alu_data       (in_r[0].data),
        .br_valid       (in_v[1]),
        .br_rob_tag     (in_r[1].tag),
        .br_pd          (in_r[1].pd),
        .br_we          (in_r[1].we),
        .br_data        (in_r[1].data),
        .mem_valid      (in_v[2]),
        .mem_rob_tag    (in_r[2].tag),
        .mem_pd         (in_r[2].pd),
        .mem_we         (in_r[2].we),
        .mem_data       (in_r[2].data),
        .alu_ready      (alu_ready),
        .br_ready       (br_ready),
        .mem_ready      (mem_ready),
        .cdb_valid      (cdb_valid),
        .cdb_rob_tag    (cdb_rob_tag),
        .cdb_pd         (cdb_pd),
        .cdb_we         (cdb_we),
        .cdb_data       (cdb_data)
    );

    always @(posedge clk) begin
        if (reset) begin
            assert (!(in_v[0] && !alu_ready)) else $error("protocol: alu_valid while alu_ready low");
            assert (!(in_v[1] && !br_ready))  else $error("protocol: br_valid while br_ready low");
            assert (!(in_v[2] && !mem_ready)) else $error("protocol: mem_valid while mem_ready low");
        end
    end

    function automatic bit younger(input logic [4:0] t, input logic [4:0] head, input logic [4:0] br);
        int age_t;
        int age_b;
        age_t = (int'(t) - int'(head) + 32) % 32;
        age_b = (int'(br) - int'(head) + 32) % 32;
        return age_t > age_b;
    endfunction

    function automatic res_t mk(input logic [4:0] t);
        res_t r;
        r.tag  = t;
        r.pd   = 7'(t) + 7'd40;
        r.we   = t[0];
        r.data = 32'hA000_0000 | 32'(t);
        return r;
    endfunction

    function automatic logic src_ready(input int s);
        return (s == 0) ? alu_ready : ((s == 1) ? br_ready : mem_ready);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        for (int s = 0; s < 3; s++) begin
            in_v[s] = 1'b0;
            in_r[s] = '0;
        end
        mispredict = 1'b0;
    endtask

    task automatic model_reset();
        for (int s = 0; s < 3; s++) mq[s].delete();
        m_rr    = 0;
        m_live  = 0;
        m_valid = 0;
        m_cdb   = '0;
    endtask

    task automatic model_step();
        bit   rdy [3];
        int   win;
        res_t keep_q [$];
        for (int s = 0; s < 3; s++) rdy[s] = m_live && (mq[s].size() < DEPTH);
        if (mispredict) begin
            for (int s = 0; s < 3; s++) begin
                keep_q = {};
                for (int i = 0; i < mq[s].size(); i++)
                    if (!younger(mq[s][i].tag, rob_head, mispredict_tag)) keep_q.push_back(mq[s][i]);
                mq[s] = keep_q;
            end
        end
        win = -1;
        for (int k = 0; k < 3; k++) begin
            int ss;
            ss = (m_rr + k) % 3;
            if (win < 0 && mq[ss].size() > 0) win = ss;
        end
        if (win >= 0) begin
            m_cdb   = mq[win].pop_front();
            m_valid = 1;
            m_rr    = (win + 1) % 3;
        end else begin
            m_valid = 0;
        end
        for (int s = 0; s < 3; s++)
            if (in_v[s] && rdy[s] && !(mispredict && younger(in_r[s].tag, rob_head, mispredict_tag)))
                mq[s].push_back(in_r[s]);
        m_live = 1;
    endtask

    task automatic check_model();
        chk("model cdb_valid", 64'(cdb_valid), 64'(m_valid));
        chk("model cdb_rob_tag", 64'(cdb_rob_tag), 64'(m_cdb.tag));
        chk("model cdb_pd", 64'(cdb_pd), 64'(m_cdb.pd));
        chk("model cdb_data", 64'(cdb_data), 64'(m_cdb.data));
        chk("model cdb_we", 64'(cdb_we), 64'(m_valid & m_cdb.we));
        chk("model alu_ready", 64'(alu_ready), 64'(m_live && mq[0].size() < DEPTH));
        chk("model br_ready", 64'(br_ready), 64'(m_live && mq[1].size() < DEPTH));
        chk("model mem_ready", 64'(mem_ready), 64'(m_live && mq[2].size() < DEPTH));
    endtask

    task automatic cycle();
        @(posedge clk);
        if (reset) model_step();
        #1;
        check_model();
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        cycle();
        chk("post_reset readies", 64'({alu_ready, br_ready, mem_ready}), 64'(3'b111));
    endtask

    task automatic drive(input int s, input logic [4:0] t);
        in_v[s] = 1'b1;
        in_r[s] = mk(t);
    endtask

    initial begin
        int seq [3];
        int prev_src;
        bit saw_full;
        int src;

        tbl[0] = '{1, 5'd4, 1, 5'd5, 1, 5'd6, 0, 5'd0};
        tbl[1] = '{0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 5'd4};
        tbl[2] = '{0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 5'd5};
        tbl[3] = '{0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 5'd6};
        tbl[4] = '{0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 5'd0};
        tbl[5] = '{0, 5'd0, 1, 5'd7, 0, 5'd0, 0, 5'd0};
        tbl[6] = '{1, 5'd9, 0, 5'd0, 1, 5'd8, 1, 5'd7};
        tbl[7] = '{0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 5'd8};
        tbl[8] = '{0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 5'd9};
        tbl[9] = '{0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 5'd0};

        clear_inputs();
        model_reset();
        #2;
        chk("reset cdb_valid", 64'(cdb_valid), 64'd0);
        chk("reset cdb fields", 64'({cdb_rob_tag, cdb_pd, cdb_we, cdb_data}), 64'd0);
        do_reset();

        // Single ALU result: visible two cycles after presentation.
        in_v[0] = 1'b1;
        in_r[0] = '{tag: 5'd3, pd: 7'd10, we: 1'b1, data: 32'h1234};
        cycle();
        chk("single t1 valid", 64'(cdb_valid), 64'd0);
        clear_inputs();
        cycle();
        chk("single t2 valid", 64'(cdb_valid), 64'd1);
        chk("single t2 fields", 64'({cdb_rob_tag, cdb_pd, cdb_we, cdb_data}),
            64'({5'd3, 7'd10, 1'b1, 32'h1234}));
        cycle();
        chk("single t3 valid", 64'(cdb_valid), 64'd0);
        chk("single t3 we", 64'(cdb_we), 64'd0);

        do_reset();
        for (int i = 0; i < 10; i++) begin
            clear_inputs();
            if (tbl[i].av) drive(0, tbl[i].at);
            if (tbl[i].bv) drive(1, tbl[i].bt);
            if (tbl[i].mv) drive(2, tbl[i].mt);
            cycle();
            chk($sformatf("table[%0d] valid", i), 64'(cdb_valid), 64'(tbl[i].ev));
            if (tbl[i].ev) chk($sformatf("table[%0d] tag", i), 64'(cdb_rob_tag), 64'(tbl[i].et));
        end

        // Mispredict with wrapped ages: head 28, branch 30.
        do_reset();
        rob_head = 5'd28;
        drive(0, 5'd28);
        cycle();
        chk("mp e1 valid", 64'(cdb_valid), 64'd0);
        clear_inputs();
        drive(0, 5'd29); drive(1, 5'd30); drive(2, 5'd2);
        cycle();
        chk("mp e2 tag", 64'({cdb_valid, cdb_rob_tag}), 64'({1'b1, 5'd28}));
        clear_inputs();
        drive(0, 5'd31);
        cycle();
        chk("mp e3 tag", 64'({cdb_valid, cdb_rob_tag}), 64'({1'b1, 5'd30}));
        chk("mp e3 alu_ready", 64'(alu_ready), 64'd0);
        clear_inputs();
        mispredict = 1'b1;
        mispredict_tag = 5'd30;
        cycle();
        chk("mp flush tag", 64'({cdb_valid, cdb_rob_tag}), 64'({1'b1, 5'd29}));
        chk("mp flush readies", 64'({alu_ready, br_ready, mem_ready}), 64'(3'b111));
        mispredict = 1'b0;
        cycle();
        chk("mp after1 valid", 64'(cdb_valid), 64'd0);
        cycle();
        chk("mp after2 valid", 64'(cdb_valid), 64'd0);

        // Branch's own tag arriving in the flush cycle survives; a younger one does not.
        mispredict = 1'b1;
        drive(0, 5'd30); drive(1, 5'd31);
        cycle();
        chk("eq flush valid", 64'(cdb_valid), 64'd0);
        clear_inputs();
        cycle();
        chk("eq tag", 64'({cdb_valid, cdb_rob_tag}), 64'({1'b1, 5'd30}));
        cycle();
        chk("eq drained", 64'(cdb_valid), 64'd0);

        // Saturating streams on all three sources.
        rob_head = 5'd0;
        seq = '{0, 0, 0};
        prev_src = -1;
        saw_full = 0;
        for (int c = 0; c < 30; c++) begin
            for (int s = 0; s < 3; s++) begin
                in_v[s] = src_ready(s);
                if (!src_ready(s) && s == 0) saw_full = 1;
                if (src_ready(s)) begin
                    in_r[s] = mk(5'(c));
                    in_r[s].data = {4'(s), 28'(seq[s])};
                    seq[s]++;
                end
            end
            cycle();
            if (c >= 3) begin
                chk("stream valid", 64'(cdb_valid), 64'd1);
                src = int'(cdb_data[31:28]);
                if (prev_src >= 0) chk("stream rotation", 64'(src), 64'((prev_src + 1) % 3));
                prev_src = src;
            end
        end
        chk("alu_ready dropped", 64'(saw_full), 64'd1);

        // Asynchronous reset mid-stream with full FIFOs.
        clear_inputs();
        #2 reset = 1'b0;
        model_reset();
        #1;
        chk("async cdb_valid", 64'(cdb_valid), 64'd0);
        chk("async cdb fields", 64'({cdb_rob_tag, cdb_pd, cdb_we, cdb_data}), 64'd0);
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        cycle();
        chk("async readies", 64'({alu_ready, br_ready, mem_ready}), 64'(3'b111));
        cycle();
        chk("async empty", 64'(cdb_valid), 64'd0);

        // Randomised traffic with occasional mispredict pulses.
        for (int c = 0; c < 400; c++) begin
            for (int s = 0; s < 3; s++) begin
                in_v[s] = src_ready(s) && ($urandom_range(0, 99) < 60);
                in_r[s] = '{tag: 5'($urandom), pd: 7'($urandom), we: 1'($urandom), data: $urandom};
            end
            mispredict = !mispredict && ($urandom_range(0, 99) < 12);
            mispredict_tag = 5'($urandom);
            if ($urandom_range(0, 99) < 5) rob_head = 5'($urandom);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cdb_writeback_arbiter.md
Name: cdb_writeback_arbiter

Overview: Consumes the per-cycle results of the ALU, branch and memory functional units and serialises them onto one registered common data bus (CDB). The CDB feeds PRF writeback, ROB completion and RS wakeup. Each source has a small FIFO with a ready signal back to its RS issue logic. Results younger than a branch mispredict are squashed wherever they sit in the block.

Parameters:
DEPTH, 2, entries per source FIFO (power of two, ≥2)
TAG_W, 5, ROB tag width
PREG_W, 7, physical register index width
DATA_W, 32, result data width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
rob_head  in  TAG_W  oldest ROB tag (age reference)
mispredict  in  1  flush request, single-cycle pulse
mispredict_tag  in  TAG_W  tag of the mispredicting branch
alu_valid / br_valid / mem_valid  in  1  result present this cycle
alu_rob_tag / br_rob_tag / mem_rob_tag  in  TAG_W  result ROB tag
alu_pd / br_pd / mem_pd  in  PREG_W  destination physical register
alu_we / br_we / mem_we  in  1  result writes a register
alu_data / br_data / mem_data  in  DATA_W  result value
alu_ready / br_ready / mem_ready  out  1  source FIFO can accept this cycle
cdb_valid  out  1  broadcast valid
cdb_rob_tag  out  TAG_W  broadcast tag
cdb_pd  out  PREG_W  broadcast destination
cdb_we  out  1  PRF write enable (cdb_valid & we)
cdb_data  out  DATA_W  broadcast value

Behaviour:
- Reset (reset=0, async): all FIFOs empty, RR pointer = ALU. cdb_valid=0, cdb_rob_tag=0, cdb_pd=0, cdb_we=0, cdb_data=0. All readies=1 one cycle after reset deasserts.
- Ready: x_ready = (count_x < DEPTH). It depends only on registered state, with no combinational path from inputs. x_valid while x_ready=0 is a protocol violation: the bench asserts on it, and the RTL drops the result.
- Accept: on a rising edge with x_valid & x_ready, the result is pushed into FIFO x.
- Latency: a result accepted at edge N into an empty block appears on the CDB after edge N+1, so it is visible two cycles after presentation. No bypass.
- Selection: at each edge, among non-empty FIFO heads, pick one by round-robin in order ALU→BR→MEM, starting at the RR pointer.
  - The winner is popped into the CDB register.
  - The pointer moves to the source after the winner.
  - If no FIFO is non-empty, cdb_valid←0 and the other CDB fields hold their values.
- Simultaneous push and pop on the same FIFO in one cycle is legal; the count is unchanged. A full FIFO may pop, but its ready still reads 0 in that cycle.
- Age: age(t) = (t − rob_head) mod 2^TAG_W. Tag t is younger than the mispredicting branch iff age(t) > age(mispredict_tag). Equal age, i.e. the branch itself, is retained.
- Flush (mispredict=1 at edge):
  - Every FIFO entry that is younger is invalidated. FIFOs are compacted, so the surviving order is preserved and counts are reduced.
  - Incoming results that are younger are not accepted.
  - The CDB register is not loaded with a younger entry. Arbitration that edge considers only surviving heads.
  - A CDB value already broadcast in the current cycle is not retracted.
- Flush and reset together: reset wins.
- Wrap-around: FIFO pointers wrap modulo DEPTH. Age arithmetic wraps modulo 2^TAG_W; rob_head=30 with tag=1 gives age 3.
- No starvation: a non-empty source is granted within 3 cycles.

Test Plan:
- Single ALU result tag=3, pd=10, data=0x1234, we=1 at cycle 0 -> cdb_valid=1 with tag=3, pd=10, data=0x1234, cdb_we=1 at cycle 2; idle otherwise.
- ALU, BR and MEM all valid in the same cycle (tags 4, 5, 6), RR pointer=ALU -> CDB carries tags 4, 5, 6 on three consecutive cycles, then cdb_valid=0.
- Hold alu_valid every cycle with DEPTH=2 while BR and MEM also stream -> alu_ready drops to 0; no result is lost or duplicated; each source is granted once per 3 cycles.
- Fill the FIFOs and pulse a mispredict:
  - Setup: rob_head=28; FIFOs hold tags 29, 31 (ALU) and 2 (MEM); mispredict_tag=30.
  - Required: tags 31 and 2 are discarded, tag 29 is broadcast, no younger tag ever reaches the CDB, and counts and readies recover.
- Result with tag=30 (equal to mispredict_tag) arrives in the flush cycle -> it is accepted and broadcast.
- Assert reset low mid-stream with full FIFOs -> all CDB outputs are 0 immediately (asynchronously), FIFOs are empty, and readies=1 after release.
